// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: data/tag types, the "no result"
// tag and the bus source encoding.
package cdb_arbiter_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ROB_W_DEF  = 4;

    typedef logic [DATA_W_DEF-1:0] DATA_TYPE;
    typedef logic [ROB_W_DEF-1:0]  ROB_POS_TYPE;

    localparam ROB_POS_TYPE ZERO_ROB = '0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;
endpackage

// File: rtl/cdb_fifo.sv
// Per-producer result queue: head is visible combinationally on dout, a pop and a push
// may share a cycle even when full, and flush empties the queue.
module cdb_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            end
        end
    end

    // Storage needs no reset: entries are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (rdy && !flush && do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between the ALU and LSB result queues, with
// registered broadcast, early stall and a sticky overflow flag.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ROB_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ROB_W-1:0]  in_alu_pos,
    input  logic [DATA_W-1:0] in_alu_value,
    input  logic [ROB_W-1:0]  in_lsb_pos,
    input  logic [DATA_W-1:0] in_lsb_value,
    input  logic              in_rob_xbp,
    output logic              out_alu_stall,
    output logic              out_lsb_stall,
    output logic [ROB_W-1:0]  out_cdb_pos,
    output logic [DATA_W-1:0] out_cdb_value,
    output logic              out_cdb_src,
    output logic              out_overflow
);
    localparam int EW = DATA_W + ROB_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          alu_push, lsb_push;
    logic          alu_pop, lsb_pop;
    logic [EW-1:0] alu_dout, lsb_dout;
    logic [CW-1:0] alu_count, lsb_count;
    logic          alu_empty, lsb_empty;
    logic          alu_full, lsb_full;
    logic          alu_drop, lsb_drop;
    logic [CW-1:0] alu_cnt_nx, lsb_cnt_nx;
    cdb_src_e      rr_ptr;

    assign alu_push = (in_alu_pos != ROB_W'(ZERO_ROB));
    assign lsb_push = (in_lsb_pos != ROB_W'(ZERO_ROB));

    always_comb begin
        alu_pop = FALSE;
        lsb_pop = FALSE;
        if (!in_rob_xbp) begin
            if (!alu_empty && !lsb_empty) begin
                if (rr_ptr == CDB_SRC_LSB) lsb_pop = TRUE;
                else                       alu_pop = TRUE;
            end else if (!alu_empty) begin
                alu_pop = TRUE;
            end else if (!lsb_empty) begin
                lsb_pop = TRUE;
            end
        end
    end

    // A push into a full queue survives only if the same queue pops this cycle.
    assign alu_drop   = alu_push && alu_full && !alu_pop;
    assign lsb_drop   = lsb_push && lsb_full && !lsb_pop;
    assign alu_cnt_nx = alu_count + {{(CW-1){1'b0}}, alu_push && !alu_drop}
                                  - {{(CW-1){1'b0}}, alu_pop};
    assign lsb_cnt_nx = lsb_count + {{(CW-1){1'b0}}, lsb_push && !lsb_drop}
                                  - {{(CW-1){1'b0}}, lsb_pop};

    cdb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst), .rdy(rdy),
        .push(alu_push), .pop(alu_pop), .flush(in_rob_xbp),
        .din({in_alu_pos, in_alu_value}), .dout(alu_dout),
        .count(alu_count), .empty(alu_empty), .full(alu_full)
    );

    cdb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk(clk), .rst(rst), .rdy(rdy),
        .push(lsb_push), .pop(lsb_pop), .flush(in_rob_xbp),
        .din({in_lsb_pos, in_lsb_value}), .dout(lsb_dout),
        .count(lsb_count), .empty(lsb_empty), .full(lsb_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= CDB_SRC_ALU;
            out_cdb_pos   <= '0;
            out_cdb_value <= '0;
            out_cdb_src   <= CDB_SRC_ALU;
            out_alu_stall <= FALSE;
            out_lsb_stall <= FALSE;
            out_overflow  <= FALSE;
        end else if (rdy) begin
            if (in_rob_xbp) begin
                rr_ptr        <= CDB_SRC_ALU;
                out_cdb_pos   <= '0;
                out_alu_stall <= FALSE;
                out_lsb_stall <= FALSE;
            end else begin
                if (alu_pop) begin
                    {out_cdb_pos, out_cdb_value} <= alu_dout;
                    out_cdb_src <= CDB_SRC_ALU;
                    rr_ptr      <= CDB_SRC_LSB;
                end else if (lsb_pop) begin
                    {out_cdb_pos, out_cdb_value} <= lsb_dout;
                    out_cdb_src <= CDB_SRC_LSB;
                    rr_ptr      <= CDB_SRC_ALU;
                end else begin
                    out_cdb_pos <= '0;
                end
                out_alu_stall <= (alu_cnt_nx >= CW'(FIFO_DEPTH - 1));
                out_lsb_stall <= (lsb_cnt_nx >= CW'(FIFO_DEPTH - 1));
                out_overflow  <= out_overflow | alu_drop | lsb_drop;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a fixed vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [3:0]  apos = '0, lpos = '0;
    logic [31:0] aval = '0, lval = '0;
    logic        xbp = 1'b0;
    logic        alu_stall, lsb_stall, cdb_src, overflow;
    logic [3:0]  cdb_pos;
    logic [31:0] cdb_value;

    int passed = 0;
    int total  = 0;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_alu_pos(apos), .in_alu_value(aval),
        .in_lsb_pos(lpos), .in_lsb_value(lval),
        .in_rob_xbp(xbp),
        .out_alu_stall(alu_stall), .out_lsb_stall(lsb_stall),
        .out_cdb_pos(cdb_pos), .out_cdb_value(cdb_value),
        .out_cdb_src(cdb_src), .out_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pos;
        logic [31:0] val;
    } entry_t;

    entry_t      aq[$];
    entry_t      lq[$];
    bit          m_next_lsb;
    logic [3:0]  m_pos;
    logic [31:0] m_val;
    logic        m_src, m_ast, m_lst, m_ovf;

    task automatic model_reset();
        aq.delete(); lq.delete();
        m_next_lsb = 0;
        m_pos = '0; m_val = '0; m_src = 0;
        m_ast = 0; m_lst = 0; m_ovf = 0;
    endtask

    // One clock edge of the arbiter described in terms of queues and whose turn it is.
    task automatic model_edge();
        entry_t e;
        int     src;
        if (rst) begin model_reset(); return; end
        if (!rdy) return;
        if (xbp) begin
            aq.delete(); lq.delete();
            m_pos = '0; m_next_lsb = 0; m_ast = 0; m_lst = 0;
            return;
        end
        src = -1;
        if (aq.size() > 0 && lq.size() > 0) src = m_next_lsb ? 1 : 0;
        else if (aq.size() > 0)             src = 0;
        else if (lq.size() > 0)             src = 1;
        if (src == 0)      begin e = aq.pop_front(); m_next_lsb = 1; end
        else if (src == 1) begin e = lq.pop_front(); m_next_lsb = 0; end
        if (src >= 0) begin m_pos = e.pos; m_val = e.val; m_src = src[0]; end
        else m_pos = '0;
        if (apos != 0) begin
            if (aq.size() < DEPTH) aq.push_back('{apos, aval}); else m_ovf = 1;
        end
        if (lpos != 0) begin
            if (lq.size() < DEPTH) lq.push_back('{lpos, lval}); else m_ovf = 1;
        end
        m_ast = (aq.size() >= DEPTH - 1);
        m_lst = (lq.size() >= DEPTH - 1);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    task automatic chk_model(string nm);
        chk({nm, ".pos"},   32'(cdb_pos),   32'(m_pos));
        chk({nm, ".value"}, cdb_value,      m_val);
        chk({nm, ".src"},   32'(cdb_src),   32'(m_src));
        chk({nm, ".astl"},  32'(alu_stall), 32'(m_ast));
        chk({nm, ".lstl"},  32'(lsb_stall), 32'(m_lst));
        chk({nm, ".ovf"},   32'(overflow),  32'(m_ovf));
    endtask

    task automatic drive(logic [3:0] ap, logic [31:0] av, logic [3:0] lp, logic [31:0] lv,
                         logic x, logic r);
        apos = ap; aval = av; lpos = lp; lval = lv; xbp = x; rdy = r;
    endtask

    task automatic step(string nm);
        @(posedge clk);
        model_edge();
        #1;
        chk_model(nm);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk_model("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  ap;
        logic [31:0] av;
        logic [3:0]  lp;
        logic [31:0] lv;
        logic [3:0]  e_pos;
        logic [31:0] e_val;
        logic        e_src, e_ast, e_lst;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Both producers push every cycle for 6 cycles, then drain.
        tbl[0]  = '{1, 32'h101,  9, 32'h209,  0, 32'h000, 0, 0, 0};
        tbl[1]  = '{2, 32'h102, 10, 32'h20a,  1, 32'h101, 0, 0, 0};
        tbl[2]  = '{3, 32'h103, 11, 32'h20b,  9, 32'h209, 1, 0, 0};
        tbl[3]  = '{4, 32'h104, 12, 32'h20c,  2, 32'h102, 0, 0, 1};
        tbl[4]  = '{5, 32'h105, 13, 32'h20d, 10, 32'h20a, 1, 1, 1};
        tbl[5]  = '{6, 32'h106, 14, 32'h20e,  3, 32'h103, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 11, 32'h20b, 1, 1, 1};
        tbl[7]  = '{0, 0, 0, 0,  4, 32'h104, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 12, 32'h20c, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,  5, 32'h105, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 13, 32'h20d, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0,  6, 32'h106, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 14, 32'h20e, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 0,  0, 32'h20e, 1, 0, 0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ap, tbl[i].av, tbl[i].lp, tbl[i].lv, 0, 1);
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("tbl%0d.pos", i),  32'(cdb_pos),   32'(tbl[i].e_pos));
            chk($sformatf("tbl%0d.val", i),  cdb_value,      tbl[i].e_val);
            chk($sformatf("tbl%0d.src", i),  32'(cdb_src),   32'(tbl[i].e_src));
            chk($sformatf("tbl%0d.astl", i), 32'(alu_stall), 32'(tbl[i].e_ast));
            chk($sformatf("tbl%0d.lstl", i), 32'(lsb_stall), 32'(tbl[i].e_lst));
            chk($sformatf("tbl%0d.ovf", i),  32'(overflow),  32'd0);
        end

        // Single ALU result: one cycle through the queue, then one cycle on the bus.
        do_reset();
        drive(3, 32'h11, 0, 0, 0, 1);
        step("single_push");
        chk("single_push.pos", 32'(cdb_pos), 32'd0);
        drive(0, 0, 0, 0, 0, 1);
        step("single_bcast");
        chk("single_bcast.pos", 32'(cdb_pos), 32'd3);
        chk("single_bcast.val", cdb_value, 32'h11);
        chk("single_bcast.src", 32'(cdb_src), 32'd0);
        step("single_idle");
        chk("single_idle.pos", 32'(cdb_pos), 32'd0);

        // Flush with ALU=2 and LSB=3 pending plus a simultaneous push of tag 7.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'(i + 1), 32'(i), 4'(i + 9), 32'(i + 100), 0, 1);
            step("fl_fill");
        end
        chk("fl_fill.asize", 32'(aq.size()), 32'd2);
        chk("fl_fill.lsize", 32'(lq.size()), 32'd3);
        drive(7, 32'h77, 0, 0, 1, 1);
        step("flush");
        chk("flush.pos", 32'(cdb_pos), 32'd0);
        drive(0, 0, 0, 0, 0, 1);
        step("flush_idle");
        chk("flush_idle.pos", 32'(cdb_pos), 32'd0);
        drive(5, 32'h55, 6, 32'h66, 0, 1);
        step("postfl_push");
        drive(0, 0, 0, 0, 0, 1);
        step("postfl_g1");
        chk("postfl_g1.pos", 32'(cdb_pos), 32'd5);
        chk("postfl_g1.src", 32'(cdb_src), 32'd0);
        step("postfl_g2");
        step("postfl_g3");

        // Both producers hammer the bus until a queue is full and a push is lost.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(4'(i % 15 + 1), 32'(i), 4'((i + 7) % 15 + 1), 32'(i + 50), 0, 1);
            step("ovf_fill");
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        drive(0, 0, 0, 0, 1, 1);
        step("ovf_flush");
        drive(0, 0, 0, 0, 0, 1);
        step("ovf_after");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // rdy low freezes everything even with traffic and flush presented.
        do_reset();
        drive(2, 32'h22, 12, 32'hcc, 0, 1);
        step("rdy_fill1");
        drive(3, 32'h33, 13, 32'hdd, 0, 1);
        step("rdy_fill2");
        for (int i = 0; i < 3; i++) begin
            drive(4'(i + 4), 32'(i), 4'(i + 1), 32'(i), i == 1, 0);
            step("rdy_hold");
            chk("rdy_hold.pos", 32'(cdb_pos), 32'd2);
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("rdy_resume");

        // Reset asserted between edges clears outputs at once; nothing stale follows.
        drive(1, 32'h1, 2, 32'h2, 0, 1);
        step("ar_fill1");
        drive(3, 32'h3, 4, 32'h4, 0, 1);
        step("ar_fill2");
        #2 rst = 1'b1;
        #1;
        chk("async_rst.pos", 32'(cdb_pos), 32'd0);
        chk("async_rst.val", cdb_value, 32'd0);
        chk("async_rst.src", 32'(cdb_src), 32'd0);
        chk("async_rst.lstl", 32'(lsb_stall), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("ar_idle");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom(),
                  ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom(),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
